// File: rtl/bin_to_bcd_pkg.sv
// Shared widths, state encoding and counter sizing for the binary-to-BCD converter.
// Imported by the add-3 digit corrector and the top-level engine.
package bin_to_bcd_pkg;

    localparam int BIN_W = 16;
    localparam int N_DIG = 4;
    localparam int DIG_W = 4;
    localparam int BCD_W = N_DIG * DIG_W;
    localparam int CNT_W = 5;

    // Index of the final shift; the engine leaves SHIFT after this bit.
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bin_to_bcd_add3.sv
// Double-dabble digit corrector: a BCD digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module bcd_add3
    import bin_to_bcd_pkg::*;
(
    input  logic [DIG_W-1:0] d,
    output logic [DIG_W-1:0] q
);

    assign q = (d >= DIG_W'(5)) ? d + DIG_W'(3) : d;

endmodule

// File: rtl/bin_to_bcd.sv
// Free-running sequential double-dabble converter: samples bin, shifts it through a
// four-digit BCD accumulator over 16 cycles, then publishes the registered digits.
module bin_to_bcd
    import bin_to_bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BIN_W-1:0] bin,
    output logic [DIG_W-1:0] un,
    output logic [DIG_W-1:0] dec,
    output logic [DIG_W-1:0] cent,
    output logic [DIG_W-1:0] milh
);

    state_t             state_reg;
    state_t             state_next;
    logic               load_en;
    logic               shift_en;
    logic               publish_en;

    logic [BIN_W-1:0]   sreg_reg;
    logic [BCD_W-1:0]   acc_reg;
    logic [BCD_W-1:0]   acc_adj;
    logic [CNT_W-1:0]   count_reg;
    logic [BCD_W-1:0]   out_reg;

    // All digits are corrected in parallel before the shift.
    generate
        for (genvar gi = 0; gi < N_DIG; gi++) begin : g_add3
            bcd_add3 u_add3 (
                .d (acc_reg[gi*DIG_W +: DIG_W]),
                .q (acc_adj[gi*DIG_W +: DIG_W])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= LOAD;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            LOAD:    state_next = SHIFT;
            SHIFT:   state_next = (count_reg == LAST_BIT) ? DONE : SHIFT;
            DONE:    state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    always_comb begin
        load_en    = 1'b0;
        shift_en   = 1'b0;
        publish_en = 1'b0;
        unique case (state_reg)
            LOAD:    load_en    = 1'b1;
            SHIFT:   shift_en   = 1'b1;
            DONE:    publish_en = 1'b1;
            default: load_en    = 1'b1;
        endcase
    end

    // The ten-thousands carry falls off the top of acc, giving bin mod 10000.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_reg  <= '0;
            acc_reg   <= '0;
            count_reg <= '0;
        end else if (load_en) begin
            sreg_reg  <= bin;
            acc_reg   <= '0;
            count_reg <= '0;
        end else if (shift_en) begin
            acc_reg   <= {acc_adj[BCD_W-2:0], sreg_reg[BIN_W-1]};
            sreg_reg  <= {sreg_reg[BIN_W-2:0], 1'b0};
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_reg <= '0;
        end else if (publish_en) begin
            out_reg <= acc_reg;
        end
    end

    assign un   = out_reg[0*DIG_W +: DIG_W];
    assign dec  = out_reg[1*DIG_W +: DIG_W];
    assign cent = out_reg[2*DIG_W +: DIG_W];
    assign milh = out_reg[3*DIG_W +: DIG_W];

endmodule

// File: tb/tb_bin_to_bcd.sv
// Self-checking bench for bin_to_bcd: a period-level decimal model checked every
// cycle, plus literal expectations for the documented reference values.
module tb_bin_to_bcd;

    logic        clk;
    logic        rst_n;
    logic [15:0] bin;
    logic [3:0]  un;
    logic [3:0]  dec;
    logic [3:0]  cent;
    logic [3:0]  milh;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    bin_to_bcd dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bin  (bin),
        .un   (un),
        .dec  (dec),
        .cent (cent),
        .milh (milh)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decimal digits of v, thousands first; values above 9999 wrap mod 10000.
    function automatic logic [15:0] to_bcd(input int unsigned v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    // Model: every 18 edges after reset release, bin is sampled on the first edge
    // and its decimal digits become visible on the eighteenth.
    int unsigned edge_cnt;
    logic [15:0] samp;
    logic [15:0] exp_bcd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt <= 0;
            samp     <= '0;
            exp_bcd  <= '0;
        end else begin
            edge_cnt <= edge_cnt + 1;
            if (edge_cnt % 18 == 0) samp <= bin;
            if (edge_cnt % 18 == 17) exp_bcd <= to_bcd(int'(samp));
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            checks++;
            if ({milh, cent, dec, un} !== exp_bcd) begin
                failures++;
                $display("FAIL model t=%0t actual=%h required=%h", $time,
                         {milh, cent, dec, un}, exp_bcd);
            end
            checks++;
            if (milh > 9 || cent > 9 || dec > 9 || un > 9) begin
                failures++;
                $display("FAIL legal_bcd t=%0t actual=%h", $time, {milh, cent, dec, un});
            end
        end
    end

    task automatic check_lit(input string name, input logic [15:0] req);
        checks++;
        if ({milh, cent, dec, un} !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, {milh, cent, dec, un}, req);
        end
    endtask

    // Starting just after a result is published: convert v and land on its result.
    task automatic convert(input logic [15:0] v);
        bin = v;
        repeat (18) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v;
        int          k;

        rst_n = 1'b0;
        bin   = 16'h0A12;
        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        check_lit("reset_state", 16'h0000);
        rst_n = 1'b1;

        repeat (17) @(negedge clk);
        check_lit("before_first_result", 16'h0000);
        @(negedge clk);
        check_lit("first_2578", 16'h2578);
        repeat (18) @(negedge clk);
        check_lit("repeat_2578", 16'h2578);

        convert(16'd0);     check_lit("zero", 16'h0000);
        convert(16'd9999);  check_lit("max_exact_9999", 16'h9999);
        convert(16'd1000);  check_lit("one_thousand", 16'h1000);
        convert(16'hFFFF);  check_lit("wrap_65535", 16'h5535);
        convert(16'd10000); check_lit("wrap_10000", 16'h0000);

        // A change of bin after the sampling edge only affects the next conversion.
        bin = 16'd2578;
        repeat (5) @(negedge clk);
        bin = 16'd1234;
        repeat (13) @(negedge clk);
        check_lit("midshift_old_value", 16'h2578);
        repeat (18) @(negedge clk);
        check_lit("midshift_new_value", 16'h1234);

        // Asynchronous reset in the middle of a conversion.
        bin = 16'd4321;
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_lit("async_reset_clear", 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (17) @(negedge clk);
        check_lit("after_reset_pending", 16'h0000);
        @(negedge clk);
        check_lit("after_reset_4321", 16'h4321);

        // Random values, with bin disturbed at a random point after sampling.
        for (int i = 0; i < 300; i++) begin
            v = (i % 2 == 0) ? 16'($urandom_range(0, 9999)) : 16'($urandom);
            bin = v;
            k = $urandom_range(1, 17);
            repeat (k) @(negedge clk);
            bin = 16'($urandom);
            repeat (18 - k) @(negedge clk);
            check_lit("random", to_bcd(int'(v)));
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
